// File: rtl/rr_arb4_pkg.sv
// Shared definitions for the 4-way round-robin arbiter: FSM encoding,
// requester count and the rotating priority search.
package rr_arb4_pkg;

    localparam int unsigned N_REQ = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // First set request found scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
    // The result is only meaningful when req is nonzero.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arb4_dec24.sv
// 2-to-4 one-hot decoder with enable; all outputs low when disabled.
module dec24
    import rr_arb4_pkg::*;
(
    input  logic [1:0]       sel,
    input  logic             en,
    output logic [N_REQ-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with owner release, request-drop
// termination and a hold limit that forcibly revokes a long grant.
module rr_arb4
    import rr_arb4_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       rel,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       tmo
);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] hold_q, hold_d;
    logic [1:0] gnt_id_q, gnt_id_d;
    logic       busy_q, busy_d;
    logic       tmo_q, tmo_d;
    logic       owner_drop;
    logic       at_limit;

    assign owner_drop = ~req[gnt_id_q];
    assign at_limit   = (hold_q == 4'(HOLD_MAX - 1));

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;
        gnt_id_d = gnt_id_q;
        busy_d   = busy_q;
        tmo_d    = 1'b0;
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (req != 4'b0000) begin
                    gnt_id_d = rr_pick(req, ptr_q);
                    busy_d   = 1'b1;
                    hold_d   = '0;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                if (rel || owner_drop || at_limit) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    ptr_d   = gnt_id_q + 2'd1;
                    hold_d  = '0;
                    // Timeout is flagged only when the limit alone ended the grant.
                    tmo_d   = at_limit && !rel && !owner_drop;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            hold_q   <= '0;
            gnt_id_q <= '0;
            busy_q   <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            hold_q   <= hold_d;
            gnt_id_q <= gnt_id_d;
            busy_q   <= busy_d;
            tmo_q    <= tmo_d;
        end
    end

    assign gnt_id = gnt_id_q;
    assign busy   = busy_q;
    assign tmo    = tmo_q;

    dec24 u_dec (
        .sel    (gnt_id_q),
        .en     (busy_q),
        .onehot (gnt)
    );

endmodule

// File: tb/tb_rr_arb4.sv
// Directed, table-driven bench for rr_arb4 with HOLD_MAX=8, plus a
// hand-written asynchronous reset sequence.
module tb_rr_arb4;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rel;
        logic [3:0] gnt;
        logic [1:0] gnt_id;
        logic       busy;
        logic       tmo;
    } vec_t;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       rel;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       tmo;

    int checks;
    int errors;
    vec_t vecs[$];

    rr_arb4 #(.HOLD_MAX(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .rel    (rel),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy),
        .tmo    (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic r, input logic [3:0] rq, input logic rl,
                       input logic [3:0] g, input logic [1:0] id,
                       input logic b, input logic t);
        vec_t v;
        v.rst = r; v.req = rq; v.rel = rl;
        v.gnt = g; v.gnt_id = id; v.busy = b; v.tmo = t;
        vecs.push_back(v);
    endtask

    task automatic check_out(input string name, input logic [3:0] g,
                             input logic [1:0] id, input logic b, input logic t);
        checks++;
        if (gnt !== g) begin
            errors++;
            $display("FAIL %s gnt: got %b expected %b", name, gnt, g);
        end
        checks++;
        if (gnt_id !== id) begin
            errors++;
            $display("FAIL %s gnt_id: got %0d expected %0d", name, gnt_id, id);
        end
        checks++;
        if (busy !== b) begin
            errors++;
            $display("FAIL %s busy: got %b expected %b", name, busy, b);
        end
        checks++;
        if (tmo !== t) begin
            errors++;
            $display("FAIL %s tmo: got %b expected %b", name, tmo, t);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        req = 4'b0000;
        rel = 1'b0;

        // Reset, then full rotation with rel on each grant's second cycle.
        add(1, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b1111, 0, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b1111, 0, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b1111, 1, 4'b0000, 2'd0, 0, 0);
        add(0, 4'b1111, 0, 4'b0010, 2'd1, 1, 0);
        add(0, 4'b1111, 0, 4'b0010, 2'd1, 1, 0);
        add(0, 4'b1111, 1, 4'b0000, 2'd1, 0, 0);
        add(0, 4'b1111, 0, 4'b0100, 2'd2, 1, 0);
        add(0, 4'b1111, 0, 4'b0100, 2'd2, 1, 0);
        add(0, 4'b1111, 1, 4'b0000, 2'd2, 0, 0);
        add(0, 4'b1111, 0, 4'b1000, 2'd3, 1, 0);
        add(0, 4'b1111, 0, 4'b1000, 2'd3, 1, 0);
        add(0, 4'b1111, 1, 4'b0000, 2'd3, 0, 0);
        add(0, 4'b1111, 0, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b1111, 1, 4'b0000, 2'd0, 0, 0);
        // Owner 1 drops its request: no tmo, then ptr=2 skips to 3.
        add(0, 4'b0010, 0, 4'b0010, 2'd1, 1, 0);
        add(0, 4'b1001, 0, 4'b0000, 2'd1, 0, 0);
        add(0, 4'b1001, 0, 4'b1000, 2'd3, 1, 0);
        // Owner 3 releases: ptr wraps to 0.
        add(0, 4'b1001, 1, 4'b0000, 2'd3, 0, 0);
        add(0, 4'b1001, 0, 4'b0001, 2'd0, 1, 0);
        add(0, 4'b0000, 1, 4'b0000, 2'd0, 0, 0);
        // Idle with no requests keeps gnt_id.
        add(0, 4'b0000, 0, 4'b0000, 2'd0, 0, 0);
        // Hold limit: 8 cycles of grant, one tmo idle cycle, regrant.
        for (int i = 0; i < 8; i++) add(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
        add(0, 4'b0100, 0, 4'b0000, 2'd2, 0, 1);
        add(0, 4'b0100, 0, 4'b0100, 2'd2, 1, 0);
        // Other requesters ignored during grant; rel at the limit suppresses tmo.
        for (int i = 0; i < 7; i++) add(0, 4'b1111, 0, 4'b0100, 2'd2, 1, 0);
        add(0, 4'b1111, 1, 4'b0000, 2'd2, 0, 0);
        add(0, 4'b0000, 0, 4'b0000, 2'd2, 0, 0);
        // ptr is now 3: request 0 wins via wrap.
        add(0, 4'b0001, 0, 4'b0001, 2'd0, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst;
            req = vecs[i].req;
            rel = vecs[i].rel;
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].gnt_id,
                      vecs[i].busy, vecs[i].tmo);
        end

        // Asynchronous reset mid-grant, checked before the next edge.
        #2;
        rst = 1'b1;
        #1;
        check_out("async_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b0010;
        rel = 1'b0;
        @(posedge clk);
        #1;
        check_out("post_rst_grant", 4'b0010, 2'd1, 1'b1, 1'b0);
        // After that owner releases, ptr=2 must pick 3 before 0.
        @(negedge clk);
        req = 4'b1001;
        rel = 1'b1;
        @(posedge clk);
        #1;
        check_out("post_rst_release", 4'b0000, 2'd1, 1'b0, 1'b0);
        @(negedge clk);
        rel = 1'b0;
        @(posedge clk);
        #1;
        check_out("post_rst_next", 4'b1000, 2'd3, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
